// File: rtl/pc_sequencer.sv
// Fetch/decode/execute sequencer driving a 2-bit program counter (inc, jnp, i1/i0, r2).
// Optional INSTR_CNT_EN adds an 8-bit saturating count of completed EXEC cycles.
module pc_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] instr,
  input  logic       p1,
  input  logic       p0,
  output logic       inc,
  output logic       jnp,
  output logic       i1,
  output logic       i0,
  output logic       r2,
`ifdef INSTR_CNT_EN
  output logic [7:0] instr_cnt,
`endif
  output logic       halted
);

  typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_INCR = 2'b01;
  localparam logic [1:0] OP_JNP  = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  state_t     r_state;
  logic [3:0] r_ir;
  logic [2:0] r_r;
  logic [2:0] w_r_next;
  logic       w_unused_pc;

  // PC value is observed for trace only; it never steers sequencing.
  assign w_unused_pc = p1 ^ p0;
  assign w_r_next    = r_r + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH;
      r_ir    <= 4'b0000;
      r_r     <= 3'b000;
      inc     <= 1'b0;
      jnp     <= 1'b0;
      i1      <= 1'b0;
      i0      <= 1'b0;
      r2      <= 1'b0;
      halted  <= 1'b0;
    end else begin
      inc      <= 1'b0;
      jnp      <= 1'b0;
      {i1, i0} <= 2'b00;
      case (r_state)
        FETCH: begin
          if (run) begin
            r_ir    <= instr;
            r_state <= DECODE;
          end
        end
        DECODE: begin
          // Pulses are loaded here so they are registered during the EXEC cycle.
          if (r_ir[3:2] == OP_HALT) begin
            r_state <= HALT;
            halted  <= 1'b1;
          end else begin
            r_state <= EXEC;
            case (r_ir[3:2])
              OP_NOP, OP_INCR: inc <= 1'b1;
              OP_JNP: begin
                jnp      <= 1'b1;
                {i1, i0} <= r_ir[1:0];
              end
              default: ;
            endcase
          end
        end
        EXEC: begin
          r_state <= FETCH;
          if (r_ir[3:2] == OP_INCR) begin
            r_r <= w_r_next;
            r2  <= w_r_next[2];
          end
        end
        HALT: r_state <= HALT;
        default: r_state <= FETCH;
      endcase
    end
  end

`ifdef INSTR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      instr_cnt <= 8'd0;
    else if (r_state == EXEC && instr_cnt != 8'hff)
      instr_cnt <= instr_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer against a fetch-timeline model of the sequencer.
module tb_pc_sequencer;

  localparam int MAXC  = 8192;
  localparam int NEVER = 1 << 30;

  logic       clk = 1'b0;
  logic       rst_n, run, p1, p0;
  logic [3:0] instr;
  logic       inc, jnp, i1, i0, r2, halted;
`ifdef INSTR_CNT_EN
  logic [7:0] instr_cnt;
`endif

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .instr(instr), .p1(p1), .p0(p0),
    .inc(inc), .jnp(jnp), .i1(i1), .i0(i0), .r2(r2),
`ifdef INSTR_CNT_EN
    .instr_cnt(instr_cnt),
`endif
    .halted(halted)
  );

  // Model: an instruction fetched at edge e pulses after edge e+1 and retires at edge e+2.
  bit       m_inc [MAXC];
  bit       m_jnp [MAXC];
  bit       m_rinc[MAXC];
  bit       m_cinc[MAXC];
  bit [1:0] m_i   [MAXC];
  int e = 0, next_fetch = 0, halt_at = NEVER, m_r = 0, m_cnt = 0;
  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, e);
    end
  endtask

  task automatic model_edge(input bit r, input logic [3:0] ins);
    if (m_rinc[e]) m_r = (m_r + 1) % 8;
    if (m_cinc[e] && m_cnt < 255) m_cnt++;
    if (e >= next_fetch && r && e + 3 < MAXC) begin
      if (ins[3:2] == 2'b11) begin
        halt_at    = e + 1;
        next_fetch = NEVER;
      end else begin
        m_inc[e+1]  = (ins[3:2] != 2'b10);
        m_jnp[e+1]  = (ins[3:2] == 2'b10);
        m_i[e+1]    = (ins[3:2] == 2'b10) ? ins[1:0] : 2'b00;
        m_rinc[e+2] = (ins[3:2] == 2'b01);
        m_cinc[e+2] = 1'b1;
        next_fetch  = e + 3;
      end
    end
  endtask

  task automatic compare(input string tag);
    logic [5:0] exp;
    exp = {m_inc[e], m_jnp[e], m_i[e], m_r[2], (e >= halt_at)};
    chk(tag, {26'd0, inc, jnp, i1, i0, r2, halted}, {26'd0, exp});
`ifdef INSTR_CNT_EN
    chk({tag, "_cnt"}, {24'd0, instr_cnt}, m_cnt);
`endif
  endtask

  task automatic cycle(input bit r, input logic [3:0] ins, input string tag);
    run   = r;
    instr = ins;
    p1    = 1'($urandom);
    p0    = 1'($urandom);
    @(posedge clk);
    e++;
    if (rst_n) model_edge(r, ins);
    #1 compare(tag);
  endtask

  // Drops rst_n mid-cycle, checks the immediate clear, holds n edges, then releases.
  task automatic do_reset(input int n);
    #2 rst_n = 1'b0;
    for (int k = e; k < MAXC; k++) begin
      m_inc[k] = 0; m_jnp[k] = 0; m_i[k] = 0; m_rinc[k] = 0; m_cinc[k] = 0;
    end
    m_r = 0; m_cnt = 0; halt_at = NEVER; next_fetch = 0;
    #1 compare("rst_async");
    for (int k = 0; k < n; k++) cycle(1'($urandom), 4'($urandom), "rst_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; instr = 4'h0; p1 = 1'b0; p0 = 1'b0;
    #1 compare("rst_init");
    for (int k = 0; k < 3; k++) cycle(1'b1, 4'h4, "rst_init_hold");
    rst_n = 1'b1;

    // JNP with R=000, then NOPs
    cycle(1'b0, 4'hb, "idle");
    for (int k = 0; k < 3; k++) cycle(1'b1, 4'hb, "jnp_r0");
    for (int k = 0; k < 9; k++) cycle(1'b1, 4'h0, "nop");
    // Eight INCRs walk R through a full wrap, with a JNP taken at R=100
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < 3; k++) cycle(1'b1, 4'h4, "incr");
      if (n == 3) for (int k = 0; k < 3; k++) cycle(1'b1, 4'hb, "jnp_r4");
    end
    // run dropped after fetch must not stall the instruction
    cycle(1'b1, 4'h9, "run_drop");
    cycle(1'b0, 4'h0, "run_drop");
    cycle(1'b0, 4'h0, "run_drop");
    // Reset landing in EXEC of an INCR: pulse truncated, R untouched
    cycle(1'b1, 4'h4, "exec_rst");
    cycle(1'b1, 4'h4, "exec_rst");
    do_reset(3);
    for (int k = 0; k < 3; k++) cycle(1'b1, 4'h8, "post_rst");

    // Randomized traffic with rare HALTs and occasional resets
    for (int c = 0; c < 1500; c++) begin
      logic [3:0] ins;
      ins = 4'($urandom);
      if (ins[3:2] == 2'b11 && $urandom_range(0, 19) != 0) ins[3:2] = 2'($urandom_range(0, 2));
      cycle($urandom_range(0, 9) < 7, ins, "rand");
      if ((e >= halt_at && e - halt_at > 12) || $urandom_range(0, 299) == 0)
        do_reset($urandom_range(1, 3));
    end

    do_reset(3);
`ifdef INSTR_CNT_EN
    for (int c = 0; c < 300 * 3 + 30; c++) cycle(1'b1, 4'h0, "nop300");
    chk("cnt_sat", {24'd0, instr_cnt}, 32'd255);
`endif

    // HALT is terminal: later run/instr activity produces nothing
    for (int k = 0; k < 3; k++) cycle(1'b1, 4'hc, "halt");
    for (int k = 0; k < 30; k++) cycle(1'($urandom), 4'($urandom), "halt_hold");
    chk("halted_final", {31'd0, halted}, 32'd1);
    do_reset(2);
    for (int k = 0; k < 6; k++) cycle(1'b1, 4'h0, "halt_exit");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port run, input, 1 bit: enables leaving FETCH; sampled only in FETCH.
REQ-004 The block SHALL have port instr, input, 4 bits: instruction word at PC address {p1,p0}; [3:2] opcode, [1:0] operand.
REQ-005 The block SHALL have ports p1 and p0, inputs, 1 bit each: current program counter value, used only for trace and verification.
REQ-006 The block SHALL have port inc, output, 1 bit: PC increment pulse.
REQ-007 The block SHALL have port jnp, output, 1 bit: conditional jump pulse to the program counter.
REQ-008 The block SHALL have ports i1 and i0, outputs, 1 bit each: jump target, valid while jnp=1.
REQ-009 The block SHALL have port r2, output, 1 bit: bit 2 of the internal 3-bit register R, the jump condition to the program counter.
REQ-010 The block SHALL have port halted, output, 1 bit: high while the FSM is in HALT.

Function
REQ-011 The FSM SHALL have states FETCH, DECODE, EXEC and HALT.
REQ-012 FETCH with run=0: hold; FETCH with run=1: latch instr into IR and go to DECODE.
REQ-013 DECODE SHALL last one cycle and go to EXEC, or to HALT if IR opcode=11.
REQ-014 EXEC SHALL last one cycle, assert the control pulse for IR, then return to FETCH; each instruction takes exactly 3 cycles with run=1.
REQ-015 Opcode 00 (NOP): inc=1 for the EXEC cycle only.
REQ-016 Opcode 01 (INCR): inc=1 for the EXEC cycle; R<=R+1 modulo 8 at the end of EXEC (7 wraps to 0).
REQ-017 Opcode 10 (JNP): jnp=1 and {i1,i0}=IR[1:0] for the EXEC cycle; inc=0.
REQ-018 The program counter loads {i1,i0} when r2=0 and increments when r2=1; the sequencer SHALL drive jnp regardless of r2.
REQ-019 Opcode 11 (HALT): HALT is terminal until reset; inc=jnp=0; halted=1; run and instr are ignored.
REQ-020 inc and jnp SHALL never both be 1 in the same cycle.
REQ-021 {i1,i0} SHALL be 00 whenever jnp=0.
REQ-022 All outputs SHALL be registered.
REQ-023 r2 SHALL change only on the clock edge that ends an INCR EXEC, so it is stable across every jnp pulse.
REQ-024 Deasserting run outside FETCH SHALL NOT stall the current instruction.

Reset
REQ-025 While rst_n=0: state=FETCH, IR=0000, R=000, inc=jnp=i1=i0=r2=halted=0, applied immediately without waiting for clk.
REQ-026 Reset asserted during EXEC SHALL truncate any pulse at once; no partial R update.
REQ-027 After rst_n rises, the first FETCH capture SHALL occur on the first rising edge of clk with run=1.

Configuration
REQ-028 With INSTR_CNT_EN defined, the block SHALL add output instr_cnt, 8 bits, counting completed EXEC cycles; it saturates at 255, resets to 0, and does not count HALT.
REQ-029 Without INSTR_CNT_EN, the instr_cnt port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-030 Reset test: rst_n=0 for 3 cycles mid-run -> all outputs 0 within the reset cycle; FETCH resumes after release.
REQ-031 NOP test: run=1, instr=0000 -> inc pulses exactly 1 cycle in every 3; jnp=0, i=00.
REQ-032 Wrap test: 8 INCR (0100) -> r2 is 0 after increments 1-3, 1 after increments 4-7, 0 after the 8th (R wraps to 000).
REQ-033 JNP test: R=000, instr=1011 -> jnp=1 with i1=1, i0=1 for 1 cycle, r2=0, inc=0; repeat with R=100 -> jnp=1, r2=1.
REQ-034 HALT test: instr=1100 -> halted=1 from the third cycle; later instr or run changes produce no pulses; only reset exits.
REQ-035 INSTR_CNT_EN test: 300 NOPs -> instr_cnt=255 and holds at 255.
